// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the CSR access sequencer.
//   - CSR instruction funct3 encodings
//   - CSR addresses used by the sequencer (trap registers, machine counters)
//   - trap-write FSM state type
//   - helper that decides whether a pipeline CSR access may write the file
package csr_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAUSE = 2'd1,
    ST_TVAL  = 2'd2
  } state_t;

  // Set/clear with a zero source is a pure read; address 0 and undefined
  // funct3 encodings never write.
  function automatic logic csr_wr_suppressed(input logic [2:0]  f3,
                                             input logic [4:0]  rs1_idx,
                                             input logic [4:0]  zimm,
                                             input logic [11:0] addr);
    logic sup;
    case (f3)
      CSRRS, CSRRC:   sup = (rs1_idx == 5'd0);
      CSRRSI, CSRRCI: sup = (zimm == 5'd0);
      CSRRW, CSRRWI:  sup = 1'b0;
      default:        sup = 1'b1;
    endcase
    return sup || (addr == 12'h000);
  endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: request side of the CSR sequencer.
//   Pipeline CSR instruction: instr_req/addr/funct3/rs1_idx/wdata/zimm in,
//   instr_gnt/instr_rdata back.
//   Trap unit: trap_req/trap_pc/trap_cause/trap_tval in, trap_done back.
//   master = pipeline + trap unit, slave = csr_access_ctrl.
interface csr_access_ctrl_if;
  logic        instr_req;
  logic [11:0] instr_addr;
  logic [2:0]  instr_funct3;
  logic [4:0]  instr_rs1_idx;
  logic [31:0] instr_wdata;
  logic [4:0]  instr_zimm;
  logic        instr_gnt;
  logic [31:0] instr_rdata;

  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        trap_done;

  modport master (
    output instr_req, instr_addr, instr_funct3, instr_rs1_idx, instr_wdata, instr_zimm,
    output trap_req, trap_pc, trap_cause, trap_tval,
    input  instr_gnt, instr_rdata, trap_done
  );

  modport slave (
    input  instr_req, instr_addr, instr_funct3, instr_rs1_idx, instr_wdata, instr_zimm,
    input  trap_req, trap_pc, trap_cause, trap_tval,
    output instr_gnt, instr_rdata, trap_done
  );
endinterface

// File: rtl/csr_hpm_counter.sv
// csr_hpm_counter: 64-bit event counter.
//   clk   - clock
//   rst_n - asynchronous active-low clear
//   inc   - count enable, one increment per enabled cycle
//   count - current value (pre-increment for the current cycle)
module csr_hpm_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [63:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (inc) count <= count + 64'd1;
  end
endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: arbiter/sequencer for the CSR file's single write port.
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus         - csr_access_ctrl_if.slave (pipeline CSR requests, trap unit)
//   retire      - instruction retired (minstret increment)
//   stall       - pipeline freeze while a trap writes mepc/mcause/mtval
//   csr_we/csr_addr/csr_funct3/csr_wdata/csr_zimm - CSR file write port
//   csr_rdata   - CSR file combinational read data for csr_addr
// Build option: CSR_COUNTER_EN hosts mcycle/minstret internally
// (0xB00/0xB80, 0xB02/0xB82), read-only, never backed by the file.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter logic [11:0] TRAP_BASE = CSR_MEPC
) (
  input  logic              clk,
  input  logic              rst_n,
  csr_access_ctrl_if.slave  bus,
  input  logic              retire,
  output logic              stall,
  output logic              csr_we,
  output logic [11:0]       csr_addr,
  output logic [2:0]        csr_funct3,
  output logic [31:0]       csr_wdata,
  output logic [4:0]        csr_zimm,
  input  logic [31:0]       csr_rdata
);

  state_t      state, state_nxt;
  logic [31:0] cause_q, tval_q;
  logic        latch_en;
  logic        gnt_c, done_c;
  logic [31:0] rdata_c;
  logic        cnt_hit;
  logic [31:0] cnt_val;

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle, minstret;

  csr_hpm_counter u_mcycle   (.clk(clk), .rst_n(rst_n), .inc(1'b1),   .count(mcycle));
  csr_hpm_counter u_minstret (.clk(clk), .rst_n(rst_n), .inc(retire), .count(minstret));

  always_comb begin
    cnt_hit = 1'b1;
    cnt_val = '0;
    case (bus.instr_addr)
      CSR_MCYCLE:    cnt_val = mcycle[31:0];
      CSR_MCYCLEH:   cnt_val = mcycle[63:32];
      CSR_MINSTRET:  cnt_val = minstret[31:0];
      CSR_MINSTRETH: cnt_val = minstret[63:32];
      default:       cnt_hit = 1'b0;
    endcase
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cnt_hit = 1'b0;
  assign cnt_val = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        cause_q <= bus.trap_cause;
        tval_q  <= bus.trap_tval;
      end
    end
  end

  // Outputs are combinational; gating on rst_n forces them to 0 for the
  // whole reset assertion, not just once the state register clears.
  always_comb begin
    state_nxt  = state;
    latch_en   = 1'b0;
    stall      = 1'b0;
    done_c     = 1'b0;
    gnt_c      = 1'b0;
    rdata_c    = '0;
    csr_we     = 1'b0;
    csr_addr   = '0;
    csr_funct3 = '0;
    csr_wdata  = '0;
    csr_zimm   = '0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (bus.trap_req) begin
            csr_we     = 1'b1;
            csr_addr   = TRAP_BASE;
            csr_funct3 = CSRRW;
            csr_wdata  = bus.trap_pc;
            stall      = 1'b1;
            latch_en   = 1'b1;
            state_nxt  = ST_CAUSE;
          end else if (bus.instr_req) begin
            gnt_c      = 1'b1;
            csr_addr   = bus.instr_addr;
            csr_funct3 = bus.instr_funct3;
            csr_wdata  = bus.instr_wdata;
            csr_zimm   = bus.instr_zimm;
            csr_we     = !cnt_hit && !csr_wr_suppressed(bus.instr_funct3, bus.instr_rs1_idx,
                                                        bus.instr_zimm, bus.instr_addr);
            if (bus.instr_addr == 12'h000) rdata_c = '0;
            else if (cnt_hit)              rdata_c = cnt_val;
            else                           rdata_c = csr_rdata;
          end
        end
        ST_CAUSE: begin
          csr_we     = 1'b1;
          csr_addr   = TRAP_BASE + 12'd1;
          csr_funct3 = CSRRW;
          csr_wdata  = cause_q;
          stall      = 1'b1;
          state_nxt  = ST_TVAL;
        end
        ST_TVAL: begin
          csr_we     = 1'b1;
          csr_addr   = TRAP_BASE + 12'd2;
          csr_funct3 = CSRRW;
          csr_wdata  = tval_q;
          stall      = 1'b1;
          done_c     = 1'b1;
          state_nxt  = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.instr_gnt   = gnt_c;
  assign bus.instr_rdata = rdata_c;
  assign bus.trap_done   = done_c;

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;
  import csr_pkg::*;

  typedef struct packed {
    logic        gnt;
    logic        we;
    logic [11:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [4:0]  zimm;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        retire;
  logic        stall;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [2:0]  csr_funct3;
  logic [31:0] csr_wdata;
  logic [4:0]  csr_zimm;
  logic [31:0] csr_rdata;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  obs_t  exp_q[$];
  string name_q[$];

  csr_access_ctrl_if bus();

  csr_access_ctrl #(.TRAP_BASE(12'h341)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .retire(retire), .stall(stall),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_funct3(csr_funct3),
    .csr_wdata(csr_wdata), .csr_zimm(csr_zimm), .csr_rdata(csr_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t sample();
    obs_t o;
    o.gnt = bus.instr_gnt;  o.we = csr_we;       o.addr = csr_addr;
    o.f3 = csr_funct3;      o.wdata = csr_wdata; o.zimm = csr_zimm;
    o.rdata = bus.instr_rdata; o.stall = stall;  o.done = bus.trap_done;
    return o;
  endfunction

  function automatic obs_t mk(input logic gnt, input logic we, input logic [11:0] addr,
                              input logic [2:0] f3, input logic [31:0] wdata,
                              input logic [4:0] zimm, input logic [31:0] rdata,
                              input logic st, input logic dn);
    obs_t e;
    e.gnt = gnt; e.we = we; e.addr = addr; e.f3 = f3; e.wdata = wdata;
    e.zimm = zimm; e.rdata = rdata; e.stall = st; e.done = dn;
    return e;
  endfunction

  function automatic void check(input string nm, input obs_t o, input obs_t e);
    nvec++;
    if (o !== e) begin
      nerr++;
      $display("FAIL %s: got gnt=%0b we=%0b addr=%h f3=%0d wdata=%h zimm=%h rdata=%h stall=%0b done=%0b; want gnt=%0b we=%0b addr=%h f3=%0d wdata=%h zimm=%h rdata=%h stall=%0b done=%0b",
               nm, o.gnt, o.we, o.addr, o.f3, o.wdata, o.zimm, o.rdata, o.stall, o.done,
               e.gnt, e.we, e.addr, e.f3, e.wdata, e.zimm, e.rdata, e.stall, e.done);
    end
  endfunction

  task automatic push(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic set_instr(input logic req, input logic [11:0] a, input logic [2:0] f,
                           input logic [4:0] rs1, input logic [31:0] wd,
                           input logic [4:0] zi, input logic [31:0] frd);
    bus.instr_req = req; bus.instr_addr = a; bus.instr_funct3 = f;
    bus.instr_rs1_idx = rs1; bus.instr_wdata = wd; bus.instr_zimm = zi;
    csr_rdata = frd;
  endtask

  task automatic set_trap(input logic req, input logic [31:0] pc,
                          input logic [31:0] cause, input logic [31:0] tval);
    bus.trap_req = req; bus.trap_pc = pc; bus.trap_cause = cause; bus.trap_tval = tval;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any visible activity must match the next queued expectation.
  initial begin
    obs_t  o;
    obs_t  e;
    string nm;
    forever begin
      @(negedge clk);
      o = sample();
      if (o.gnt || o.we || o.stall || o.done) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_activity: got gnt=%0b we=%0b addr=%h wdata=%h stall=%0b done=%0b; want no activity",
                   o.gnt, o.we, o.addr, o.wdata, o.stall, o.done);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, o, e);
        end
      end
    end
  end

  initial begin
    retire = 1'b0;
    rst_n  = 1'b0;
    set_trap(1'b0, '0, '0, '0);
    set_instr(1'b1, 12'h305, CSRRW, 5'd1, 32'hDEADBEEF, 5'd0, 32'h12345678);
    #3;
    check("reset_outputs_zero", sample(), '0);
    next_cycle();
    rst_n = 1'b1;
    set_instr(1'b0, '0, '0, '0, '0, '0, '0);
    next_cycle();

    // Pipeline accesses, granted and visible in the same cycle.
    set_instr(1'b1, 12'h305, CSRRW, 5'd1, 32'hDEADBEEF, 5'd0, 32'h12345678);
    push("csrrw_305", mk(1, 1, 12'h305, 3'd1, 32'hDEADBEEF, 5'd0, 32'h12345678, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'h300, CSRRS, 5'd0, 32'h5, 5'd0, 32'hAA);
    push("csrrs_rs1_zero", mk(1, 0, 12'h300, 3'd2, 32'h5, 5'd0, 32'hAA, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'h304, CSRRCI, 5'd3, 32'h0, 5'd0, 32'h88);
    push("csrrci_zimm_zero", mk(1, 0, 12'h304, 3'd7, 32'h0, 5'd0, 32'h88, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'h000, CSRRW, 5'd1, 32'h11, 5'd0, 32'h999);
    push("addr_zero", mk(1, 0, 12'h000, 3'd1, 32'h11, 5'd0, 32'h0, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'h340, 3'b000, 5'd1, 32'h22, 5'd0, 32'h33);
    push("funct3_undef", mk(1, 0, 12'h340, 3'd0, 32'h22, 5'd0, 32'h33, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'h300, CSRRSI, 5'd0, 32'h0, 5'd3, 32'h44);
    push("csrrsi_zimm3", mk(1, 1, 12'h300, 3'd6, 32'h0, 5'd3, 32'h44, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'h300, CSRRC, 5'd5, 32'hF0, 5'd0, 32'h55);
    push("csrrc_rs1_5", mk(1, 1, 12'h300, 3'd3, 32'hF0, 5'd0, 32'h55, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'h340, CSRRWI, 5'd0, 32'h0, 5'd0, 32'h1);
    push("csrrwi_zimm_zero", mk(1, 1, 12'h340, 3'd5, 32'h0, 5'd0, 32'h1, 0, 0));
    next_cycle();
    set_instr(1'b0, '0, '0, '0, '0, '0, '0);
    next_cycle();

    // Trap collides with a held instruction; retrigger in CAUSE is ignored.
    set_instr(1'b1, 12'h305, CSRRW, 5'd1, 32'hCAFE, 5'd0, 32'h777);
    set_trap(1'b1, 32'h80, 32'h2, 32'h55);
    push("trap_mepc", mk(0, 1, 12'h341, 3'd1, 32'h80, 5'd0, 32'h0, 1, 0));
    next_cycle();
    set_trap(1'b1, 32'h99, 32'h7, 32'h77);
    push("trap_mcause", mk(0, 1, 12'h342, 3'd1, 32'h2, 5'd0, 32'h0, 1, 0));
    next_cycle();
    set_trap(1'b0, '0, '0, '0);
    push("trap_mtval", mk(0, 1, 12'h343, 3'd1, 32'h55, 5'd0, 32'h0, 1, 1));
    next_cycle();
    push("instr_after_trap", mk(1, 1, 12'h305, 3'd1, 32'hCAFE, 5'd0, 32'h777, 0, 0));
    next_cycle();
    set_instr(1'b0, '0, '0, '0, '0, '0, '0);
    next_cycle();

    // Reset in TVAL: mtval write must never appear.
    set_trap(1'b1, 32'h100, 32'h3, 32'h44);
    push("rst_trap_mepc", mk(0, 1, 12'h341, 3'd1, 32'h100, 5'd0, 32'h0, 1, 0));
    next_cycle();
    set_trap(1'b0, '0, '0, '0);
    push("rst_trap_mcause", mk(0, 1, 12'h342, 3'd1, 32'h3, 5'd0, 32'h0, 1, 0));
    next_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_tval", sample(), '0);
    next_cycle();
    rst_n = 1'b1;
    set_instr(1'b1, 12'h305, CSRRW, 5'd1, 32'hAB, 5'd0, 32'h12);
    push("instr_after_reset", mk(1, 1, 12'h305, 3'd1, 32'hAB, 5'd0, 32'h12, 0, 0));
    next_cycle();
    set_instr(1'b0, '0, '0, '0, '0, '0, '0);

    // Level trap_req held: second trap starts right after trap_done.
    set_trap(1'b1, 32'h200, 32'h8, 32'h66);
    push("lvl_mepc", mk(0, 1, 12'h341, 3'd1, 32'h200, 5'd0, 32'h0, 1, 0));
    next_cycle();
    push("lvl_mcause", mk(0, 1, 12'h342, 3'd1, 32'h8, 5'd0, 32'h0, 1, 0));
    next_cycle();
    push("lvl_mtval", mk(0, 1, 12'h343, 3'd1, 32'h66, 5'd0, 32'h0, 1, 1));
    next_cycle();
    push("lvl_mepc_again", mk(0, 1, 12'h341, 3'd1, 32'h200, 5'd0, 32'h0, 1, 0));
    next_cycle();
    set_trap(1'b0, '0, '0, '0);
    push("lvl_mcause_again", mk(0, 1, 12'h342, 3'd1, 32'h8, 5'd0, 32'h0, 1, 0));
    next_cycle();
    push("lvl_mtval_again", mk(0, 1, 12'h343, 3'd1, 32'h66, 5'd0, 32'h0, 1, 1));
    next_cycle();

`ifdef CSR_COUNTER_EN
    force dut.u_mcycle.count = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_mcycle.count;
    next_cycle();
    set_instr(1'b1, 12'hB80, CSRRS, 5'd0, 32'h0, 5'd0, 32'hBAD);
    push("mcycleh_wrap", mk(1, 0, 12'hB80, 3'd2, 32'h0, 5'd0, 32'h1, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'hB00, CSRRW, 5'd1, 32'h5, 5'd0, 32'hBAD);
    push("mcycle_write_ignored", mk(1, 0, 12'hB00, 3'd1, 32'h5, 5'd0, 32'h1, 0, 0));
    next_cycle();
    set_instr(1'b1, 12'hB00, CSRRS, 5'd0, 32'h0, 5'd0, 32'hBAD);
    push("mcycle_after_write", mk(1, 0, 12'hB00, 3'd2, 32'h0, 5'd0, 32'h2, 0, 0));
    next_cycle();
    set_instr(1'b0, '0, '0, '0, '0, '0, '0);
`endif

    next_cycle();
    next_cycle();
    if (exp_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
